// File: rtl/sdt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdt_pkg
//  Description : Shared types and constants for the SDT memory slave.
//  Revision    : 1.0  initial release
// ============================================================================
package sdt_pkg;

  // Slave transfer phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } sdt_state_e;

  // Operation latched from the request pins.
  typedef enum logic [1:0] {
    SDT_RD  = 2'd0,
    SDT_WR  = 2'd1,
    SDT_BAD = 2'd2
  } sdt_op_e;

  // Largest supported WAIT_STATES value.
  localparam int SDT_MAX_WAIT = 15;

  // Both strobes high at once is a protocol violation.
  function automatic sdt_op_e sdt_decode_op(input logic i_rd, input logic i_wr);
    sdt_op_e w_op;
    if (i_rd && i_wr)   w_op = SDT_BAD;
    else if (i_wr)      w_op = SDT_WR;
    else                w_op = SDT_RD;
    return w_op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdt_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : sdt_regfile
//  Description : DEPTH x DATA_WIDTH register file, synchronous write,
//                asynchronous clear, combinational read.
//  Revision    : 1.0  initial release
// ============================================================================
module sdt_regfile
  import sdt_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [IDX_WIDTH-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [IDX_WIDTH-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Storage: whole array cleared by reset, one word written per enabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sdt_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : sdt_mem_slave
//  Description : SDT slave endpoint with internal memory, programmable wait
//                states and error response for bad/out-of-range requests.
//  Revision    : 1.0  initial release
// ============================================================================
module sdt_mem_slave
  import sdt_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ack,
  output logic                  err
);

  localparam int c_CNT_WIDTH = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int c_IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_CNT_WIDTH-1:0] c_CNT_LOAD  = c_CNT_WIDTH'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0]    c_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  generate
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
      $fatal(1, "sdt_mem_slave: DEPTH must be in 1..2**ADDR_WIDTH");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > SDT_MAX_WAIT) begin : g_bad_wait
      $fatal(1, "sdt_mem_slave: WAIT_STATES must be in 0..15");
    end
  endgenerate

  sdt_state_e             r_state, w_state_nxt;
  logic [c_CNT_WIDTH-1:0] r_cnt,   w_cnt_nxt;
  sdt_op_e                r_op;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_rd_data, w_rd_data_nxt;
  logic                   r_ack,   w_ack_nxt;
  logic                   r_err,   w_err_nxt;
  logic                   w_latch;
  logic                   w_we;
  logic                   w_in_range;
  logic [DATA_WIDTH-1:0]  w_mem_rdata;

  assign w_in_range = ({1'b0, r_addr} < c_DEPTH_EXT);

  sdt_regfile #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (c_IDX_WIDTH)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_addr[c_IDX_WIDTH-1:0]),
    .i_wdata (r_wdata),
    .i_raddr (r_addr[c_IDX_WIDTH-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // State, counter, request latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_op      <= SDT_RD;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      if (w_latch) begin
        r_op    <= sdt_decode_op(rd, wr);
        r_addr  <= addr;
        r_wdata <= wr_data;
      end
    end
  end

  // Next state and ACK-entry actions. Every request spends at least one cycle
  // in WAIT; loading the counter with WAIT_STATES puts ack WAIT_STATES+1 edges
  // after the sampling edge and keeps the ACK cycle from re-sampling a held request.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_latch       = 1'b0;
    w_ack_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    w_rd_data_nxt = r_rd_data;
    w_we          = 1'b0;
    case (r_state)
      IDLE: begin
        if (rd || wr) begin
          w_latch     = 1'b1;
          w_state_nxt = WAIT;
          w_cnt_nxt   = c_CNT_LOAD;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ACK;
          w_ack_nxt   = 1'b1;
          case (r_op)
            SDT_RD: begin
              if (w_in_range) begin
                w_rd_data_nxt = w_mem_rdata;
              end else begin
                w_rd_data_nxt = '0;
                w_err_nxt     = 1'b1;
              end
            end
            SDT_WR: begin
              if (w_in_range) w_we = 1'b1;
              else            w_err_nxt = 1'b1;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rd_data = r_rd_data;
  assign ack     = r_ack;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdt_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdt_mem_slave
//  Description : Self-checking bench for sdt_mem_slave; three instances with
//                different wait-state/depth settings against a memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdt_mem_slave;

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;
  logic [2:0] rd  = '0;
  logic [2:0] wr  = '0;
  logic [7:0] addr  [3];
  logic [7:0] wdata [3];
  logic [7:0] rdata [3];
  logic [2:0] ack;
  logic [2:0] err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int ws_of    [3] = '{0, 3, 5};
  int depth_of [3] = '{256, 16, 256};

  logic [7:0] mdl [3][256];
  logic [7:0] mrd [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdt_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst[0]), .rd(rd[0]), .wr(wr[0]), .addr(addr[0]),
    .wr_data(wdata[0]), .rd_data(rdata[0]), .ack(ack[0]), .err(err[0]));

  sdt_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst[1]), .rd(rd[1]), .wr(wr[1]), .addr(addr[1]),
    .wr_data(wdata[1]), .rd_data(rdata[1]), .ack(ack[1]), .err(err[1]));

  sdt_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .WAIT_STATES(5)) u_ws5 (
    .clk(clk), .rst(rst[2]), .rd(rd[2]), .wr(wr[2]), .addr(addr[2]),
    .wr_data(wdata[2]), .rd_data(rdata[2]), .ack(ack[2]), .err(err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void clear_model(input int k);
    for (int i = 0; i < 256; i++) mdl[k][i] = 8'h00;
    mrd[k] = 8'h00;
  endfunction

  // One full transfer on instance k, starting just after a rising edge.
  task automatic xfer(input int k, input logic r, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input bit scramble, output int ack_at);
    int   n;
    bit   seen;
    logic exp_err;
    exp_err = 1'b0;
    if (r && w) begin
      exp_err = 1'b1;
    end else if (r) begin
      if (int'(a) < depth_of[k]) mrd[k] = mdl[k][a];
      else begin mrd[k] = 8'h00; exp_err = 1'b1; end
    end else if (w) begin
      if (int'(a) < depth_of[k]) mdl[k][a] = d;
      else exp_err = 1'b1;
    end
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d;
    @(posedge clk); #1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      if (scramble) begin
        addr[k]  = 8'($urandom);
        wdata[k] = 8'($urandom);
        if ($urandom_range(0, 3) == 0) begin rd[k] = 1'b0; wr[k] = 1'b0; end
      end
      @(posedge clk); #1;
      n++;
      if (ack[k]) seen = 1'b1;
    end
    check($sformatf("k%0d latency a=%0h", k, a), n, ws_of[k] + 1);
    check($sformatf("k%0d err a=%0h", k, a), err[k], exp_err);
    check($sformatf("k%0d rd_data a=%0h", k, a), rdata[k], mrd[k]);
    ack_at = cyc;
    rd[k] = 1'b0; wr[k] = 1'b0;
    @(posedge clk); #1;
    check($sformatf("k%0d ack_one_cycle", k), ack[k], 1'b0);
    check($sformatf("k%0d err_low_idle", k), err[k], 1'b0);
  endtask

  initial begin
    int t1, t2, acks_seen;
    for (int k = 0; k < 3; k++) begin
      clear_model(k);
      addr[k] = '0; wdata[k] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("k%0d reset ack", k), ack[k], 1'b0);
      check($sformatf("k%0d reset err", k), err[k], 1'b0);
      check($sformatf("k%0d reset rd_data", k), rdata[k], 8'h00);
    end
    rst = 3'b000;
    @(posedge clk); #1;

    // Basic write then read, zero wait states
    xfer(0, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, t1);
    xfer(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, t1);
    check("basic rd A5", rdata[0], 8'hA5);

    // Back-to-back write/read: one IDLE cycle between ack pulses
    xfer(0, 1'b0, 1'b1, 8'h01, 8'h3C, 1'b0, t1);
    xfer(0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, t2);
    check("b2b ack spacing", t2 - t1, 3);
    check("b2b rd 3C", rdata[0], 8'h3C);

    // Protocol error keeps rd_data, memory untouched
    xfer(0, 1'b0, 1'b1, 8'h02, 8'h77, 1'b0, t1);
    xfer(0, 1'b1, 1'b1, 8'h02, 8'h11, 1'b0, t1);
    check("bad keeps rd_data", rdata[0], 8'h3C);
    xfer(0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, t1);
    check("after bad rd 77", rdata[0], 8'h77);

    // Wait-state timing and out-of-range on the 16-word instance
    xfer(1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, t1);
    xfer(1, 1'b0, 1'b1, 8'h20, 8'hFF, 1'b0, t1);
    xfer(1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, t1);
    check("oor no alias", rdata[1], 8'h00);
    xfer(1, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, t1);

    // Reset in the middle of a wait-state transfer
    xfer(2, 1'b0, 1'b1, 8'h05, 8'h5A, 1'b0, t1);
    xfer(2, 1'b0, 1'b1, 8'h06, 8'hC3, 1'b0, t1);
    xfer(2, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, t1);
    rd[2] = 1'b1; addr[2] = 8'h06;
    repeat (3) @(posedge clk);
    #2 rst[2] = 1'b1;
    #1;
    check("midrst ack", ack[2], 1'b0);
    check("midrst err", err[2], 1'b0);
    check("midrst rd_data", rdata[2], 8'h00);
    rd[2] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst[2] = 1'b0;
    clear_model(2);
    acks_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ack[2]) acks_seen++;
    end
    check("midrst no late ack", acks_seen, 0);
    xfer(2, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, t1);
    xfer(2, 1'b1, 1'b0, 8'h06, 8'h00, 1'b0, t1);

    // Randomized traffic on every instance, inputs scrambled during WAIT
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 25; i++) begin
        int   sel;
        logic r, w;
        sel = $urandom_range(0, 9);
        r = (sel >= 4);
        w = (sel < 4) || (sel == 9);
        xfer(k, r, w, 8'($urandom_range(0, 31)), 8'($urandom), 1'($urandom_range(0, 1)), t1);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
